// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;
  typedef enum logic {LAST_INSTR, LAST_DATA} last_e;

  // Data starts as "most recently granted" so instr wins the first conflict.
  localparam last_e RESET_LAST = LAST_DATA;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin grant unit (bit 0 = instr, bit 1 = data).
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  last_e      last,
  output logic [1:0] gnt
);

  // One-hot grant; on conflict favour whoever was not granted last.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == LAST_DATA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one latency-1 single-port RAM between the instr and data ports.
// Optional perf counters: define MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]             perf_conflict_o,
  output logic [31:0]             perf_instr_stall_o
`endif
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0] req, gnt;
  owner_e     owner_q, owner_d;
  last_e      last_q, last_d;

  // Requests are masked in reset so no grant can leak out.
  assign req = {data_req_i, instr_req_i} & {2{~rst_i}};

  rr_arb2 u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];
  assign mem_req_o   = |gnt;

  // Drive the RAM from the granted port; all-zero when idle.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt[0]) begin
      mem_addr_o = instr_addr_i;
      mem_be_o   = {BE_W{1'b1}};
    end else if (gnt[1]) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Next owner of the response slot and round-robin history.
  always_comb begin
    owner_d = OWN_NONE;
    last_d  = last_q;
    if (gnt[0]) begin
      owner_d = OWN_INSTR;
      last_d  = LAST_INSTR;
    end else if (gnt[1]) begin
      owner_d = OWN_DATA;
      last_d  = LAST_DATA;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
      last_q  <= RESET_LAST;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Route the RAM read data to whichever port owns this cycle's response.
  always_comb begin
    instr_rvalid_o = (owner_q == OWN_INSTR) && !rst_i;
    data_rvalid_o  = (owner_q == OWN_DATA) && !rst_i;
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_q, conflict_d, stall_q, stall_d;

  // Saturating event counters for conflicts and instr stalls.
  always_comb begin
    conflict_d = conflict_q;
    stall_d    = stall_q;
    if (instr_req_i && data_req_i) conflict_d = sat_inc(conflict_q);
    if (instr_req_i && !instr_gnt_o) stall_d = sat_inc(stall_q);
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      stall_q    <= stall_d;
    end
  end

  assign perf_conflict_o    = conflict_q;
  assign perf_instr_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset corner cases,
// random hold-until-grant traffic against a byte-enable RAM model.
module tb_mem_port_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req, data_req, data_we;
  logic [AW-1:0] instr_addr, data_addr;
  logic [3:0]    data_be;
  logic [DW-1:0] data_wdata;
  logic          instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [DW-1:0] instr_rdata, data_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   perf_conflict, perf_instr_stall;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_conflict_o(perf_conflict), .perf_instr_stall_o(perf_instr_stall)
`endif
  );

  // RAM model: latency 1, returns the old word on every access, byte-enable writes.
  logic [DW-1:0] ram [4096];
  logic          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int k = 0; k < 4096; k++) ram[k] <= '0;
      ram[12'h060] <= 32'h1111_0180;
      ram[12'h061] <= 32'h2222_0184;
      ram[12'h062] <= 32'h3333_0188;
      ram[12'h080] <= 32'hAAAA_0200;
      ram[12'h081] <= 32'hBBBB_0204;
      ram_init <= 1'b1;
      mem_rdata <= '0;
    end else if (mem_req) begin
      mem_rdata <= ram[mem_addr[13:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst, ireq; logic [AW-1:0] ia;
    logic dreq; logic [AW-1:0] da; logic we; logic [3:0] be; logic [31:0] wd;
    logic igt, dgt; logic [AW-1:0] ma; logic mwe; logic [3:0] mbe; logic [31:0] mwd;
    logic irv, drv; logic [31:0] ird, drd;
  } vec_t;

  function automatic vec_t mk(
      input logic rst, ireq, input logic [AW-1:0] ia,
      input logic dreq, input logic [AW-1:0] da, input logic we,
      input logic [3:0] be, input logic [31:0] wd,
      input logic igt, dgt, input logic [AW-1:0] ma, input logic mwe,
      input logic [3:0] mbe, input logic [31:0] mwd,
      input logic irv, drv, input logic [31:0] ird, drd);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.ia = ia; v.dreq = dreq; v.da = da; v.we = we;
    v.be = be; v.wd = wd; v.igt = igt; v.dgt = dgt; v.ma = ma; v.mwe = mwe;
    v.mbe = mbe; v.mwd = mwd; v.irv = irv; v.drv = drv; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic drive(input logic r, ir, input logic [AW-1:0] ia, input logic dr,
                       input logic [AW-1:0] da, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    rst = r; instr_req = ir; instr_addr = ia; data_req = dr; data_addr = da;
    data_we = we; data_be = be; data_wdata = wd;
  endtask

  vec_t vecs[$];

  // Random-phase state
  logic [DW-1:0] shadow [4096];
  logic          ih, dh, dwe, exp_irv, exp_drv, chk_ird, chk_drd;
  logic [AW-1:0] ra_i, ra_d;
  logic [3:0]    dbe;
  logic [31:0]   dwd, exp_ird, exp_drd;
  int            iwait, dwait;

  initial begin
    drive(1'b1, 0, '0, 0, '0, 0, '0, '0);

    //        rst ireq ia      dreq da      we be    wd            igt dgt ma      mwe mbe   mwd           irv drv ird           drd
    vecs.push_back(mk(1, 1, 20'h180, 1, 20'h200, 0, 4'hF, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 20'h180, 0, 20'h0,   0, 4'h0, 32'h0,         1, 0, 20'h180, 0, 4'hF, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 20'h184, 0, 20'h0,   0, 4'h0, 32'h0,         1, 0, 20'h184, 0, 4'hF, 32'h0,         1, 0, 32'h1111_0180, 32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         1, 0, 32'h2222_0184, 32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   1, 20'h1000,1, 4'h3, 32'hDEADBEEF,  0, 1, 20'h1000,1, 4'h3, 32'hDEADBEEF,  0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   1, 20'h1000,0, 4'hF, 32'h0,         0, 1, 20'h1000,0, 4'hF, 32'h0,         0, 1, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 1, 32'h0,         32'h0000_BEEF));
    vecs.push_back(mk(1, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 20'h180, 1, 20'h200, 0, 4'hF, 32'h0,         1, 0, 20'h180, 0, 4'hF, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 20'h184, 1, 20'h200, 0, 4'hF, 32'h0,         0, 1, 20'h200, 0, 4'hF, 32'h0,         1, 0, 32'h1111_0180, 32'h0));
    vecs.push_back(mk(0, 1, 20'h184, 1, 20'h204, 0, 4'hF, 32'h0,         1, 0, 20'h184, 0, 4'hF, 32'h0,         0, 1, 32'h0,         32'hAAAA_0200));
    vecs.push_back(mk(0, 1, 20'h188, 1, 20'h204, 0, 4'hF, 32'h0,         0, 1, 20'h204, 0, 4'hF, 32'h0,         1, 0, 32'h2222_0184, 32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 1, 32'h0,         32'hBBBB_0204));
    vecs.push_back(mk(0, 0, 20'h0,   1, 20'h200, 0, 4'hF, 32'h0,         0, 1, 20'h200, 0, 4'hF, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 1, 20'h180, 1, 20'h200, 0, 4'hF, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 20'h180, 1, 20'h200, 0, 4'hF, 32'h0,         1, 0, 20'h180, 0, 4'hF, 32'h0,         0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 20'h0,   0, 20'h0,   0, 4'h0, 32'h0,         0, 0, 20'h0,   0, 4'h0, 32'h0,         1, 0, 32'h1111_0180, 32'h0));

    // Directed table: drive after the edge, check combinational and registered outputs.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].ireq, vecs[i].ia, vecs[i].dreq, vecs[i].da,
            vecs[i].we, vecs[i].be, vecs[i].wd);
      #3;
      chk($sformatf("row%0d instr_gnt", i), 32'(instr_gnt), 32'(vecs[i].igt));
      chk($sformatf("row%0d data_gnt", i), 32'(data_gnt), 32'(vecs[i].dgt));
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(vecs[i].igt | vecs[i].dgt));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].ma));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
      chk($sformatf("row%0d mem_be", i), 32'(mem_be), 32'(vecs[i].mbe));
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
      chk($sformatf("row%0d instr_rvalid", i), 32'(instr_rvalid), 32'(vecs[i].irv));
      chk($sformatf("row%0d data_rvalid", i), 32'(data_rvalid), 32'(vecs[i].drv));
      chk($sformatf("row%0d instr_rdata", i), instr_rdata, vecs[i].ird);
      chk($sformatf("row%0d data_rdata", i), data_rdata, vecs[i].drd);
    end

    // Random traffic: each port holds its request until granted.
    @(posedge clk); #1;
    drive(0, 0, '0, 0, '0, 0, '0, '0);
    for (int k = 0; k < 4096; k++) shadow[k] = ram[k];
    ih = 0; dh = 0; exp_irv = 0; exp_drv = 0; chk_ird = 0; chk_drd = 0;
    exp_ird = '0; exp_drd = '0; iwait = 0; dwait = 0;
    ra_i = '0; ra_d = '0; dwe = 0; dbe = '0; dwd = '0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (!ih && $urandom_range(0, 2) != 0) begin
        ih = 1; ra_i = AW'({$urandom_range(0, 15), 2'b00});
      end
      if (!dh && $urandom_range(0, 2) != 0) begin
        dh = 1; ra_d = AW'({$urandom_range(0, 15), 2'b00});
        dwe = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
      end
      drive(0, ih, ra_i, dh, ra_d, dwe, dbe, dwd);
      #3;
      chk("rnd instr_rvalid", 32'(instr_rvalid), 32'(exp_irv));
      chk("rnd data_rvalid", 32'(data_rvalid), 32'(exp_drv));
      if (chk_ird) chk("rnd instr_rdata", instr_rdata, exp_ird);
      if (chk_drd) chk("rnd data_rdata", data_rdata, exp_drd);
      chk("rnd one-hot gnt", 32'(instr_gnt & data_gnt), 32'(0));
      if (ih ^ dh) chk("rnd lone gnt", 32'({data_gnt, instr_gnt}), 32'({dh, ih}));
      exp_irv = 0; exp_drv = 0; chk_ird = 0; chk_drd = 0;
      if (instr_gnt) begin
        chk("rnd instr mem_addr", 32'(mem_addr), 32'(ra_i));
        exp_irv = 1; chk_ird = 1; exp_ird = shadow[ra_i[13:2]];
        ih = 0; iwait = 0;
      end else if (ih) iwait++;
      if (data_gnt) begin
        chk("rnd data mem_addr", 32'(mem_addr), 32'(ra_d));
        exp_drv = 1; chk_drd = !dwe; exp_drd = shadow[ra_d[13:2]];
        if (dwe)
          for (int b = 0; b < 4; b++)
            if (dbe[b]) shadow[ra_d[13:2]][8*b +: 8] = dwd[8*b +: 8];
        dh = 0; dwait = 0;
      end else if (dh) dwait++;
      if (iwait > 1 || dwait > 1) chk("rnd max wait", 32'(iwait > dwait ? iwait : dwait), 32'(1));
    end
    // Drain the final response.
    @(posedge clk); #1;
    drive(0, 0, '0, 0, '0, 0, '0, '0);
    #3;
    chk("rnd last instr_rvalid", 32'(instr_rvalid), 32'(exp_irv));
    chk("rnd last data_rvalid", 32'(data_rvalid), 32'(exp_drv));

`ifdef MEM_ARB_PERF_CNT_EN
    // Six conflict cycles from reset: instr stalls on every other one.
    @(posedge clk); #1;
    drive(1, 0, '0, 0, '0, 0, '0, '0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(0, 1, 20'h180, 1, 20'h200, 0, 4'hF, '0);
    end
    @(posedge clk); #1;
    drive(0, 0, '0, 0, '0, 0, '0, '0);
    #3;
    chk("perf_conflict", perf_conflict, 32'd6);
    chk("perf_instr_stall", perf_instr_stall, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency-1 RAM between the core instruction port and data port. Both ports use the core's req/gnt/rvalid protocol.
- Sits between the core and the RAM array in the testbench memory subsystem. It replaces the dual-ported access with one physical port.
- Round-robin arbitration with a one-entry response tracker that routes read data back to the correct requester.

Parameters:
- ADDR_WIDTH, 20, RAM byte-address width for both ports and the memory side.
- DATA_WIDTH, 32, data/instruction word width; must be a multiple of 8.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch byte address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  DATA_WIDTH  fetch data.
- data_req_i  in  1  load/store request.
- data_addr_i  in  ADDR_WIDTH  load/store byte address.
- data_we_i  in  1  1 = store.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  load/store request accepted this cycle.
- data_rvalid_o  out  1  load data valid, or store completion.
- data_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o  out  1  RAM access strobe.
- mem_addr_o  out  ADDR_WIDTH  RAM address.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables.
- mem_wdata_o  out  DATA_WIDTH  RAM write data.
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid exactly 1 cycle after mem_req_o.

Behaviour:
- Protocol per port:
  - A request is held with stable address, we, be and wdata until gnt.
  - gnt is combinational and appears in the same cycle as req.
  - rvalid is asserted exactly 1 cycle after gnt, for one cycle, for both reads and writes.
  - Requesters may issue a new request in the same cycle they receive rvalid.
- Arbitration (combinational):
  - Only instr requesting: grant instr.
  - Only data requesting: grant data.
  - Both requesting: grant the port that was not granted most recently (last_q).
  - No requests: no grant; mem_req_o = 0.
- At most one gnt is high per cycle. mem_req_o equals the OR of the gnts.
- Memory mux:
  - Memory side is driven from the granted port.
  - Instr grants force mem_we_o = 0 and mem_be_o = all-ones.
  - When idle, mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are 0.
- State registers:
  - last_q (INSTR/DATA): updated on every grant; holds when idle. Reset value DATA, so instr wins the first conflict.
  - owner_q (NONE/INSTR/DATA): set to the granted port each cycle; NONE when nothing is granted.
- Response routing:
  - instr_rvalid_o = (owner_q == INSTR); data_rvalid_o = (owner_q == DATA).
  - The owning port's rdata equals mem_rdata_i. The non-owning port's rdata is 0.
- Throughput and latency:
  - Back-to-back grants every cycle are allowed; no bubble is inserted.
  - Sustained conflict alternates grants: instr, data, instr, ...
- Reset behaviour:
  - Reset values: owner_q = NONE, last_q = DATA.
  - All gnt and rvalid outputs are 0 while rst_i is high, regardless of requests. rdata outputs are 0.
  - Reset asserted in the cycle after a grant drops that response: no rvalid is issued.
- Boundary conditions:
  - Addresses pass through unchanged.
  - A store to a word while instr fetches the same word in the same cycle resolves purely by round-robin. No forwarding is performed.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_conflict_o [31:0]: counts cycles where both req inputs are high.
  - perf_instr_stall_o [31:0]: counts cycles where instr_req_i is high and instr_gnt_o is low.
- Both counters are saturating at 32'hFFFF_FFFF and cleared by rst_i.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_INSTR, OWN_DATA}.
  - typedef enum logic last_e {LAST_INSTR, LAST_DATA}.
  - localparam RESET_LAST = LAST_DATA.
- Sub-module rr_arb2: a two-requester round-robin grant unit.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt[1:0].
  - Purely combinational. Reused by the top level and available for future multi-port variants.

Test Plan:
- Instr only, addr 0x180 then 0x184 in consecutive cycles:
  - instr_gnt_o high in both cycles; rvalid 1 cycle after each, with RAM contents.
  - data_rvalid_o stays 0 throughout.
- Data store of 0xDEADBEEF to 0x1000 with be = 4'b0011, then a load from 0x1000:
  - mem_be_o = 0011 on the store; data_rvalid_o follows both accesses.
  - The load returns 0x0000BEEF over a prior zero word.
- Both ports request for 4 cycles immediately after reset:
  - Grants are instr, data, instr, data; each rvalid is routed to the matching port with that port's data.
- Reset asserted in the cycle after a data grant:
  - No data_rvalid_o.
  - After reset release, the first conflict is granted to instr.
- Random req/stall mix for 10k cycles against a RAM model:
  - Never two gnts in one cycle.
  - Every gnt is followed by exactly one rvalid on the same port.
  - No port waits more than 1 cycle under conflict.
- With MEM_ARB_PERF_CNT_EN defined, 6 conflict cycles:
  - perf_conflict_o = 6.
  - perf_instr_stall_o = 3.
